icache_ctrl: RTL and testbench
==============================

# icache_ctrl

Direct-mapped instruction cache placed between the CPU fetch stage and a multi-cycle backing memory. It replaces the single-cycle instruction memory on the fetch path. On a hit it returns the instruction in the same cycle. On a miss it raises `stall`, fetches the whole 4-word line from backing memory, fills the line and then serves the hit. The CPU holds `pc` and IF/ID while `stall` is high.

## Interface
Parameters:
- `LINES`, default 8: number of cache lines; power of two.
- `WORDS`, default 4: 16-bit words per line; fixed at 4 in this revision.

Ports:
- `clk`, input, 1: single clock; all state updates on posedge.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `addr`, input, 16: word address of the fetch (CPU `pc`).
- `rd_en`, input, 1: fetch request this cycle.
- `flush`, input, 1: invalidate all lines.
- `instr`, output, 16: fetched instruction; valid when `rd_en & ~stall`.
- `stall`, output, 1: miss in progress; the CPU freezes fetch.
- `mem_re`, output, 1: line read request to backing memory.
- `mem_addr`, output, 14: line address, equal to `addr[15:2]` of the missing fetch.
- `mem_rdy`, input, 1: one-cycle pulse; `mem_rd_data` is valid in that cycle.
- `mem_rd_data`, input, 64: line data; word k is on bits [16k+15:16k].
- `hit_cnt`, output, 16: saturating count of hit cycles.
- `miss_cnt`, output, 16: saturating count of misses; counts once per miss.

## Operation
- Address split for `LINES`=8: offset `addr[1:0]`, index `addr[4:2]`, tag `addr[15:5]` (11 bits).
- Storage per line: valid bit, tag, and 4×16 data words. All valid bits clear on reset and on `flush`. Data and tag contents are don't-care at reset.
- Hit means `rd_en & valid[index] & (tag[index]==addr tag)`. On a hit, `instr` = data[index][offset], combinational.
- State machine:
  - IDLE: on `rd_en & ~hit`, latch `addr[15:2]` into the miss register, increment `miss_cnt`, go to FETCH. If `rd_en` is low, do nothing.
  - FETCH: hold `mem_re`=1 and `mem_addr`=latched line address. On `mem_rdy`, write the data and tag into the line at the latched index, set its valid bit, and go to IDLE.
- `stall` = (IDLE & `rd_en` & ~hit) | FETCH.
- `instr` = 16'h0000 (pipeline bubble) whenever `stall` is high or `rd_en` is low.
- `hit_cnt` increments in each cycle with `rd_en & hit` in IDLE. Both counters saturate at 16'hFFFF.
- `flush`:
  - In IDLE: clears all valid bits; takes priority over a same-cycle miss detection, which then re-misses next cycle.
  - In FETCH: clears valid bits and marks the pending fill as discarded. The fill data is still written on `mem_rdy`, but valid is not set; the state returns to IDLE and the fetch misses again.
- Address change during FETCH (branch redirect): the fill completes to the latched address. Back in IDLE the new `addr` is looked up normally.
- A `mem_rdy` seen in IDLE is ignored.

## Timing
- Reset values: state IDLE; `stall`=0 while `rd_en`=0; `instr`=0; `mem_re`=0; `mem_addr`=0; `hit_cnt`=0; `miss_cnt`=0; all valid bits 0.
- Reset asserted mid-FETCH: `mem_re` drops asynchronously, state goes to IDLE, and the later `mem_rdy` is ignored.
- Hit latency is 0 cycles (combinational from `addr`).
- Miss timing:
  - Cycle 0: miss detected, `stall`=1.
  - Cycle 1 onward: `mem_re`=1.
  - Fill happens at the edge ending the `mem_rdy` cycle R.
  - Cycle R+1: hit, `stall`=0.
  - Penalty is R+1 stall cycles; with memory answering M cycles after `mem_re` first rises, this is M+2.
- `mem_re` stays high from the cycle after detection through the `mem_rdy` cycle inclusive, and drops the cycle after.
- Only one outstanding memory request at a time.

## Structure
- Shared package `icache_pkg` holds:
  - `OFF_W`=2, `IDX_W`=$clog2(LINES), `TAG_W`=16-OFF_W-IDX_W;
  - state enum IDLE/FETCH;
  - `NOP_INSTR`=16'h0000.
- Sub-module `icache_array` holds the tag, valid and data storage: one combinational read port, one line-write port, and a flush-all input. The FSM, miss register and counters stay in `icache_ctrl`.

## Test plan
- Cold miss: reset, then `rd_en`=1, `addr`=16'h0000, memory answering after 3 cycles with line {4,3,2,1} → `stall` high for 5 cycles, `mem_addr`=0, then `instr`=16'h0001 with `miss_cnt`=1.
- Same-line hits: after the cold fill, `addr`=1,2,3 on consecutive cycles → `instr`=2,3,4, `stall`=0 throughout, `hit_cnt`=3.
- Conflict eviction: fill `addr` 16'h0000, then fetch 16'h0020 (same index, tag 1) → miss with `mem_addr`=14'h0008; refetching 16'h0000 misses again.
- Flush during FETCH: `flush` pulsed one cycle before `mem_rdy` → line not valid, the same `addr` misses again, and `miss_cnt` increments twice.
- Reset mid-FETCH: drop `rst_n` while `mem_re`=1 → `mem_re`=0 immediately, counters 0, a later `mem_rdy` pulse causes no fill, and the first fetch afterwards misses.
- Redirect during FETCH: change `addr` to 16'h0045 mid-miss → line 0 is filled, then 16'h0045 misses with `mem_addr`=14'h0011.

Source files
------------

// File: rtl/icache_pkg.sv
// icache_pkg: shared widths, FSM state type and bubble instruction for the instruction cache.
// Address split: offset [1:0], index [OFF_W+IDX_W-1:OFF_W], tag [15:OFF_W+IDX_W].
package icache_pkg;
  localparam int LINES_DEF = 8;
  localparam int OFF_W = 2;
  localparam int IDX_W = $clog2(LINES_DEF);
  localparam int TAG_W = 16 - OFF_W - IDX_W;
  localparam logic [15:0] NOP_INSTR = 16'h0000;
  typedef enum logic {IDLE, FETCH} state_t;
endpackage

// File: rtl/icache_if.sv
// icache_if: line-fill bus between the cache (master) and backing memory (slave).
// mem_re/mem_addr: line read request and 14-bit line address.
// mem_rdy/mem_rd_data: one-cycle response pulse carrying the whole 64-bit line.
interface icache_if;
  logic        mem_re;
  logic [13:0] mem_addr;
  logic        mem_rdy;
  logic [63:0] mem_rd_data;
  modport master (output mem_re, mem_addr, input mem_rdy, mem_rd_data);
  modport slave (input mem_re, mem_addr, output mem_rdy, mem_rd_data);
endinterface

// File: rtl/icache_array.sv
// icache_array: valid/tag/data storage for a direct-mapped cache.
// Read port: rd_idx/rd_off -> rd_valid, rd_tag, rd_word (combinational).
// Write port: we writes wr_tag/wr_line at wr_idx and sets valid to wr_valid.
// flush clears every valid bit; a same-cycle write may still set its own line.
module icache_array
  import icache_pkg::*;
#(
  parameter int LINES = 8,
  parameter int WORDS = 4,
  localparam int IW = $clog2(LINES),
  localparam int TW = 16 - OFF_W - IW
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic [IW-1:0]      rd_idx,
  input  logic [OFF_W-1:0]   rd_off,
  output logic               rd_valid,
  output logic [TW-1:0]      rd_tag,
  output logic [15:0]        rd_word,
  input  logic               we,
  input  logic [IW-1:0]      wr_idx,
  input  logic [TW-1:0]      wr_tag,
  input  logic               wr_valid,
  input  logic [WORDS*16-1:0] wr_line
);
  logic [LINES-1:0]    valid_q, valid_d;
  logic [TW-1:0]       tag_q [LINES];
  logic [WORDS*16-1:0] data_q [LINES];
  always_comb begin
    valid_d = flush ? '0 : valid_q;
    if (we) valid_d[wr_idx] = wr_valid;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) valid_q <= '0;
    else valid_q <= valid_d;
  // Tag and data need no reset: they are only observed behind a valid bit.
  always_ff @(posedge clk)
    if (we) begin
      tag_q[wr_idx]  <= wr_tag;
      data_q[wr_idx] <= wr_line;
    end
  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_word  = data_q[rd_idx][{rd_off, 4'b0000} +: 16];
endmodule

// File: rtl/icache_ctrl.sv
// icache_ctrl: direct-mapped instruction cache controller on the fetch path.
// Fetch side: addr/rd_en/flush in, instr (0 on bubble) and stall out.
// Memory side: mem (icache_if master) fetches whole lines on a miss.
// Stats: hit_cnt/miss_cnt saturating 16-bit counters.
module icache_ctrl
  import icache_pkg::*;
#(
  parameter int LINES = 8,
  parameter int WORDS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] addr,
  input  logic        rd_en,
  input  logic        flush,
  output logic [15:0] instr,
  output logic        stall,
  icache_if.master    mem,
  output logic [15:0] hit_cnt,
  output logic [15:0] miss_cnt
);
  localparam int IW = $clog2(LINES);
  localparam int TW = 16 - OFF_W - IW;
  state_t      state_q, state_d;
  logic [13:0] line_q, line_d;
  logic        discard_q, discard_d;
  logic [15:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;
  logic        rd_valid, hit, we, wr_valid;
  logic [TW-1:0] rd_tag;
  logic [15:0] rd_word;
  icache_array #(.LINES(LINES), .WORDS(WORDS)) u_array (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .rd_idx   (addr[OFF_W +: IW]),
    .rd_off   (addr[OFF_W-1:0]),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_word  (rd_word),
    .we       (we),
    .wr_idx   (line_q[IW-1:0]),
    .wr_tag   (line_q[13 -: TW]),
    .wr_valid (wr_valid),
    .wr_line  (mem.mem_rd_data)
  );
  assign hit = rd_en & rd_valid & (rd_tag == addr[15 -: TW]);
  always_comb begin
    state_d    = state_q;
    line_d     = line_q;
    discard_d  = discard_q;
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    we         = 1'b0;
    wr_valid   = 1'b0;
    if (state_q == IDLE) begin
      hit_cnt_d = (hit && hit_cnt_q != 16'hFFFF) ? hit_cnt_q + 16'd1 : hit_cnt_q;
      // A same-cycle flush suppresses the miss; the fetch re-misses next cycle.
      if (rd_en && !hit && !flush) begin
        state_d    = FETCH;
        line_d     = addr[15:2];
        discard_d  = 1'b0;
        miss_cnt_d = (miss_cnt_q != 16'hFFFF) ? miss_cnt_q + 16'd1 : miss_cnt_q;
      end
    end else begin
      // A flush during the fill poisons it: data lands but the line stays invalid.
      discard_d = discard_q | flush;
      if (mem.mem_rdy) begin
        we       = 1'b1;
        wr_valid = ~(discard_q | flush);
        state_d  = IDLE;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q    <= IDLE;
      line_q     <= '0;
      discard_q  <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      line_q     <= line_d;
      discard_q  <= discard_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  assign stall        = (state_q == FETCH) | (rd_en & ~hit);
  assign instr        = (rd_en & ~stall) ? rd_word : NOP_INSTR;
  assign mem.mem_re   = state_q == FETCH;
  assign mem.mem_addr = line_q;
  assign hit_cnt      = hit_cnt_q;
  assign miss_cnt     = miss_cnt_q;
endmodule

// File: tb/tb_icache_ctrl.sv
// tb_icache_ctrl: directed scenarios plus randomized fetch traffic against a behavioural cache model.
module tb_icache_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] addr = '0;
  logic        rd_en = 1'b0;
  logic        flush = 1'b0;
  logic [15:0] instr, hit_cnt, miss_cnt;
  logic        stall;
  icache_if mif ();
  icache_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .addr     (addr),
    .rd_en    (rd_en),
    .flush    (flush),
    .instr    (instr),
    .stall    (stall),
    .mem      (mif),
    .hit_cnt  (hit_cnt),
    .miss_cnt (miss_cnt)
  );
  always #5 clk = ~clk;
  int checks = 0;
  int failures = 0;
  bit          m_valid [8];
  logic [10:0] m_tag [8];
  logic [15:0] m_data [8][4];
  bit          m_fetch, m_disc;
  logic [13:0] m_line;
  int          m_cnt, m_hits, m_misses;
  int          fixed_delay = 3;
  logic        obs_stall, obs_mem_re;
  logic [15:0] obs_instr, obs_miss, obs_hit;
  logic [13:0] last_mem_addr;
  function automatic logic [15:0] word_of(input logic [13:0] line, input int k);
    return {line, 2'(k)} + 16'd1;
  endfunction
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_valid[i] = 0;
    m_fetch = 0;
    m_disc = 0;
    m_hits = 0;
    m_misses = 0;
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    addr = '0;
    rd_en = 1'b0;
    flush = 1'b0;
    mif.mem_rdy = 1'b0;
    mif.mem_rd_data = '0;
    model_reset();
    #1;
    chk("rst_stall", stall, 0);
    chk("rst_instr", instr, 0);
    chk("rst_mem_re", mif.mem_re, 0);
    chk("rst_mem_addr", mif.mem_addr, 0);
    chk("rst_hit_cnt", hit_cnt, 0);
    chk("rst_miss_cnt", miss_cnt, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask
  // One clock cycle: apply inputs, compare DUT to the model mid-cycle, advance the model at the edge.
  task automatic step(input logic [15:0] a, input logic r, input logic f, input logic spur);
    logic [2:0]  idx;
    logic [13:0] dl;
    logic        hit, e_stall;
    logic [15:0] e_instr;
    addr = a;
    rd_en = r;
    flush = f;
    mif.mem_rdy = m_fetch ? (m_cnt == 0) : spur;
    dl = m_fetch ? m_line : 14'($urandom);
    for (int k = 0; k < 4; k++) mif.mem_rd_data[16*k +: 16] = word_of(dl, k);
    #4;
    idx = a[4:2];
    hit = r && m_valid[idx] && m_tag[idx] == a[15:5];
    e_stall = m_fetch || (r && !hit);
    e_instr = (r && !e_stall) ? m_data[idx][a[1:0]] : 16'h0000;
    chk("instr", instr, e_instr);
    chk("stall", stall, e_stall);
    chk("mem_re", mif.mem_re, m_fetch);
    if (m_fetch) chk("mem_addr", mif.mem_addr, m_line);
    chk("hit_cnt", hit_cnt, m_hits);
    chk("miss_cnt", miss_cnt, m_misses);
    obs_stall = stall;
    obs_instr = instr;
    obs_miss = miss_cnt;
    obs_hit = hit_cnt;
    obs_mem_re = mif.mem_re;
    if (mif.mem_re) last_mem_addr = mif.mem_addr;
    @(posedge clk);
    if (!m_fetch) begin
      if (hit && m_hits < 65535) m_hits++;
      if (f) begin
        for (int i = 0; i < 8; i++) m_valid[i] = 0;
      end else if (r && !hit) begin
        m_line = a[15:2];
        m_fetch = 1;
        m_disc = 0;
        if (m_misses < 65535) m_misses++;
        m_cnt = fixed_delay >= 0 ? fixed_delay : int'($urandom_range(0, 4));
      end
    end else begin
      if (f) begin
        for (int i = 0; i < 8; i++) m_valid[i] = 0;
        m_disc = 1;
      end
      if (mif.mem_rdy) begin
        idx = m_line[2:0];
        m_tag[idx] = m_line[13:3];
        for (int k = 0; k < 4; k++) m_data[idx][k] = word_of(m_line, k);
        if (!m_disc) m_valid[idx] = 1;
        m_fetch = 0;
      end else m_cnt--;
    end
    #1;
  endtask
  // Fetch a until it is served; n returns the number of stall cycles seen.
  task automatic run_until_hit(input logic [15:0] a, output int n);
    bit done = 0;
    n = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      step(a, 1'b1, 1'b0, 1'b0);
      if (!obs_stall) done = 1;
      else n++;
    end
    if (!done) chk("hit_timeout", 0, 1);
  endtask
  initial begin
    int n, m0, h0;
    #1;
    do_reset();
    // Cold miss: 3-cycle memory -> 5 stall cycles, then the first word.
    run_until_hit(16'h0000, n);
    chk("cold_stall_cycles", n, 5);
    chk("cold_mem_addr", last_mem_addr, 14'h0000);
    chk("cold_instr", obs_instr, 16'h0001);
    chk("cold_miss_cnt", obs_miss, 1);
    // Same-line hits.
    h0 = int'(obs_hit);
    step(16'h0001, 1'b1, 1'b0, 1'b0);
    chk("hit1_instr", obs_instr, 16'h0002);
    h0 = int'(obs_hit);
    step(16'h0002, 1'b1, 1'b0, 1'b0);
    chk("hit2_instr", obs_instr, 16'h0003);
    step(16'h0003, 1'b1, 1'b0, 1'b0);
    chk("hit3_instr", obs_instr, 16'h0004);
    chk("hit3_stall", obs_stall, 0);
    step(16'h0003, 1'b0, 1'b0, 1'b0);
    chk("hit_cnt_delta", int'(obs_hit) - h0, 3);
    chk("idle_instr", obs_instr, 16'h0000);
    // Conflict eviction.
    run_until_hit(16'h0020, n);
    chk("conflict_mem_addr", last_mem_addr, 14'h0008);
    chk("conflict_instr", obs_instr, 16'h0021);
    run_until_hit(16'h0000, n);
    chk("refetch_stall_cycles", n, 5);
    // Flush one cycle before mem_rdy discards the fill.
    step(16'h0040, 1'b1, 1'b0, 1'b0);
    m0 = int'(obs_miss);
    step(16'h0040, 1'b1, 1'b0, 1'b0);
    step(16'h0040, 1'b1, 1'b0, 1'b0);
    step(16'h0040, 1'b1, 1'b1, 1'b0);
    step(16'h0040, 1'b1, 1'b0, 1'b0);
    step(16'h0040, 1'b1, 1'b0, 1'b0);
    chk("flush_remiss", obs_stall, 1);
    run_until_hit(16'h0040, n);
    chk("flush_miss_cnt", int'(obs_miss) - m0, 2);
    chk("flush_instr", obs_instr, 16'h0041);
    // Reset in the middle of a fill.
    step(16'h0080, 1'b1, 1'b0, 1'b0);
    step(16'h0080, 1'b1, 1'b0, 1'b0);
    chk("midrst_mem_re_before", obs_mem_re, 1);
    do_reset();
    step(16'h0000, 1'b0, 1'b0, 1'b1);
    step(16'h0080, 1'b1, 1'b0, 1'b0);
    chk("midrst_remiss", obs_stall, 1);
    run_until_hit(16'h0080, n);
    chk("midrst_instr", obs_instr, 16'h0081);
    // Redirect during fetch: line 0 still fills, then 0x0045 misses.
    step(16'h0000, 1'b1, 1'b0, 1'b0);
    run_until_hit(16'h0045, n);
    chk("redirect_mem_addr", last_mem_addr, 14'h0011);
    chk("redirect_instr", obs_instr, 16'h0046);
    step(16'h0000, 1'b1, 1'b0, 1'b0);
    chk("redirect_line0_stall", obs_stall, 0);
    chk("redirect_line0_instr", obs_instr, 16'h0001);
    // Randomized traffic with random memory latency, flushes and stray mem_rdy pulses.
    fixed_delay = -1;
    for (int i = 0; i < 3000; i++) begin
      logic [15:0] a;
      a = ($urandom_range(0, 15) == 0) ? 16'($urandom) : {9'd0, 2'($urandom), 5'($urandom)};
      step(a, $urandom_range(0, 9) < 8, $urandom_range(0, 39) == 0, $urandom_range(0, 9) == 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
